ifetch_pq: RTL and testbench
============================

Name: ifetch_pq

Overview:
- Parametrised prefetching instruction-fetch stage. It is the successor to the single-register fetch stage.
- Issues in-order requests to instruction memory with variable latency and buffers returned words in a DEPTH-entry queue.
- Presents one instruction plus its address per cycle to decode, under stall backpressure.
- Branch redirects flush the queue and discard stale in-flight responses.

Parameters:
- ADDR, 16, address width; the PC wraps modulo 2^ADDR.
- WORD, 32, instruction width.
- DEPTH, 4, queue depth and credit limit; must be a power of 2 and at least 2.
- RESET_PC, 0, PC value after reset.
- INC, 1, address increment per instruction.

Ports:
- clk  in  1  clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req_o  out  1  fetch request valid.
- mem_addr_o  out  ADDR  fetch address; equals pc.
- mem_gnt_i  in  1  memory accepts the request this cycle (effective only while mem_req_o=1).
- mem_rvalid_i  in  1  response data valid; responses return in request order.
- mem_rdata_i  in  WORD  response data.
- branch_i  in  1  redirect this cycle.
- branch_addr_i  in  ADDR  redirect target.
- stall_i  in  1  decode cannot accept; hold the current output.
- inst_valid_o  out  1  queue head valid.
- inst_o  out  WORD  head instruction.
- inst_addr_o  out  ADDR  address of the head instruction.

Behaviour:
- Reset (asynchronous, rst=1):
  - pc=RESET_PC, head_addr=RESET_PC; queue count, out_cnt and drop_cnt = 0; queue storage = 0.
  - Outputs: mem_req_o=0, mem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_addr_o=RESET_PC.
  - Reset mid-operation aborts everything. Responses arriving after rst deasserts for pre-reset requests are the memory's responsibility; the memory must be reset together with this block.
- State:
  - pc: next fetch address.
  - out_cnt: live outstanding requests.
  - drop_cnt: stale outstanding requests.
  - Queue: circular FIFO of WORD entries with count 0..DEPTH.
  - head_addr: address of the queue head.
  - All counters are clog2(DEPTH)+1 bits wide.
- Request:
  - mem_req_o = !rst & !branch_i & (out_cnt + count < DEPTH). This is combinational; there is no dependence on mem_gnt_i.
  - On req & gnt: pc <= pc+INC (wraps) and out_cnt increments.
- Response:
  - On mem_rvalid_i with drop_cnt>0: drop_cnt decrements and the data is discarded.
  - Otherwise, if out_cnt>0: push the data into the queue and decrement out_cnt.
  - rvalid with both counters at 0 is a protocol violation and is ignored.
- Output:
  - inst_valid_o = (count != 0); inst_o = queue head (registered storage); inst_addr_o = head_addr.
  - Pop when inst_valid_o & !stall_i: head advances and head_addr <= head_addr+INC.
  - A push to an empty queue is visible the next cycle (1-cycle response-to-output latency).
  - Push and pop may occur in the same cycle, at any count.
  - Overflow cannot occur because of the credit rule.
- Stall:
  - Fetching continues under stall until out_cnt + count = DEPTH, then mem_req_o drops.
  - inst_o and inst_addr_o hold stable while stalled.
- Branch (priority over pop, push and request in the same cycle):
  - pc <= branch_addr_i; head_addr <= branch_addr_i; count <= 0.
  - drop_cnt <= drop_cnt + out_cnt − (rvalid this cycle ? 1 : 0); out_cnt <= 0.
  - mem_req_o=0 during the branch cycle. The first request to the target occurs the next cycle.
  - A response arriving in the branch cycle is discarded.
  - inst_valid_o is 0 in the cycle after a branch.
- Drops and in-flight limit:
  - New requests are permitted while drop_cnt>0.
  - Total in flight ≤ 2·DEPTH; the memory must accept that.
- Arithmetic:
  - All address arithmetic is modulo 2^ADDR; wrap from max to 0 has no special handling.
- Back-to-back branches: each branch re-applies the branch rules; drop_cnt accumulates correctly.

Test Plan:
- Common setup: DEPTH=4, INC=1; memory model has 2-cycle latency, always grants, and returns data = {16'hA5A5, addr}.
1. Reset then free-run, stall=0 -> requests at 0,1,2,…. First inst_valid_o 3 cycles after the first request, with inst_o=A5A50000 and inst_addr_o=0. After that, one instruction per cycle with consecutive addresses.
2. Hold stall_i=1 from first valid -> exactly 4 requests outstanding or queued, then mem_req_o=0. inst_o holds A5A50000. After release, instructions 0..3 are emitted in 4 consecutive cycles, then the stream continues at 4.
3. branch_i with branch_addr_i=16'h0100 while 2 requests are in flight and the queue holds 2 -> the 2 stale responses are discarded and inst_valid_o=0 until the response for 0x0100 arrives. Next outputs are addresses 0x0100, 0x0101.
4. Branch asserted in the same cycle as rvalid and pop, with stall=0 -> no push, no pop, drop_cnt equals the prior out_cnt−1, and the first output is the target address.
5. Branch to 16'hFFFE with free-run -> output addresses FFFE, FFFF, 0000, 0001.
6. rst asserted mid-stream (asynchronously, between clock edges) -> all outputs take their reset values immediately. After release, fetch restarts at RESET_PC with no stale output.

Source files
------------

// File: rtl/ifetch_pq.sv
// Prefetching instruction-fetch stage: credit-limited in-order requests, DEPTH-entry
// return queue, one instruction per cycle to decode, branch flush with stale-response drop.
`timescale 1ns/1ps
module ifetch_pq #(
    parameter int unsigned     ADDR     = 16,
    parameter int unsigned     WORD     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [ADDR-1:0] RESET_PC = {ADDR{1'b0}},
    parameter logic [ADDR-1:0] INC      = {{(ADDR-1){1'b0}}, 1'b1}
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_o,
    output logic [ADDR-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [WORD-1:0] mem_rdata_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] branch_addr_i,
    input  logic            stall_i,
    output logic            inst_valid_o,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] inst_addr_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);

    logic [ADDR-1:0] pc_q, pc_d;
    logic [ADDR-1:0] head_addr_q, head_addr_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [WORD-1:0] queue_q [DEPTH];

    logic [CW:0]     credit_sum_s;
    logic [CW:0]     stale_sum_s;
    logic            fire_s;
    logic            drop_s;
    logic            push_s;
    logic            pop_s;

    // Credit counts both outstanding requests and queued words so the queue can never overflow.
    assign credit_sum_s = {1'b0, out_cnt_q} + {1'b0, count_q};
    assign stale_sum_s  = {1'b0, drop_cnt_q} + {1'b0, out_cnt_q};
    assign mem_req_o    = !rst && !branch_i && (credit_sum_s < (CW+1)'(DEPTH));
    assign fire_s       = mem_req_o && mem_gnt_i;
    assign drop_s       = mem_rvalid_i && (drop_cnt_q != {CW{1'b0}});
    assign push_s       = mem_rvalid_i && !drop_s && (out_cnt_q != {CW{1'b0}}) && !branch_i;
    assign pop_s        = (count_q != {CW{1'b0}}) && !stall_i && !branch_i;

    assign mem_addr_o   = pc_q;
    assign inst_valid_o = (count_q != {CW{1'b0}});
    assign inst_o       = queue_q[rd_ptr_q];
    assign inst_addr_o  = head_addr_q;

    // Next-state for PC, counters and queue pointers; a branch overrides everything else.
    always_comb begin
        pc_d        = pc_q;
        head_addr_d = head_addr_q;
        out_cnt_d   = out_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        if (branch_i) begin
            pc_d        = branch_addr_i;
            head_addr_d = branch_addr_i;
            count_d     = {CW{1'b0}};
            rd_ptr_d    = {PW{1'b0}};
            wr_ptr_d    = {PW{1'b0}};
            out_cnt_d   = {CW{1'b0}};
            // Every live request becomes stale; a response landing now retires one of them.
            if (mem_rvalid_i && (stale_sum_s != {(CW+1){1'b0}})) begin
                drop_cnt_d = CW'(stale_sum_s - {{CW{1'b0}}, 1'b1});
            end else begin
                drop_cnt_d = CW'(stale_sum_s);
            end
        end else begin
            if (fire_s) begin
                pc_d = pc_q + INC;
            end else begin
                pc_d = pc_q;
            end
            out_cnt_d  = out_cnt_q + CW'(fire_s) - CW'(push_s);
            drop_cnt_d = drop_cnt_q - CW'(drop_s);
            count_d    = count_q + CW'(push_s) - CW'(pop_s);
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d    = rd_ptr_q + PW'(1'b1);
                head_addr_d = head_addr_q + INC;
            end else begin
                rd_ptr_d    = rd_ptr_q;
                head_addr_d = head_addr_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            head_addr_q <= RESET_PC;
            out_cnt_q   <= {CW{1'b0}};
            drop_cnt_q  <= {CW{1'b0}};
            count_q     <= {CW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            wr_ptr_q    <= {PW{1'b0}};
        end else begin
            pc_q        <= pc_d;
            head_addr_q <= head_addr_d;
            out_cnt_q   <= out_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // Queue storage; cleared on reset so inst_o reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                queue_q[i] <= {WORD{1'b0}};
            end
        end else if (push_s) begin
            queue_q[wr_ptr_q] <= mem_rdata_i;
        end else begin
            queue_q[wr_ptr_q] <= queue_q[wr_ptr_q];
        end
    end

endmodule

// File: tb/tb_ifetch_pq.sv
// Directed bench for ifetch_pq: 2-cycle always-granting memory returning {16'hA5A5, addr}.
`timescale 1ns/1ps
module tb_ifetch_pq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        branch, stall, inst_valid;
    logic [15:0] branch_addr, inst_addr;
    logic [31:0] inst;
    int          n_total = 0;
    int          n_bad   = 0;

    logic        v1_q, v2_q;
    logic [15:0] a1_q, a2_q;

    ifetch_pq #(.ADDR(16), .WORD(32), .DEPTH(4), .RESET_PC(16'h0000), .INC(16'h0001)) dut (
        .clk(clk), .rst(rst),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .branch_i(branch), .branch_addr_i(branch_addr), .stall_i(stall),
        .inst_valid_o(inst_valid), .inst_o(inst), .inst_addr_o(inst_addr)
    );

    always #5 clk = ~clk;

    assign mem_gnt    = 1'b1;
    assign mem_rvalid = v2_q;
    assign mem_rdata  = {16'hA5A5, a2_q};

    // Two-stage memory pipeline, reset together with the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0; v2_q <= 1'b0; a1_q <= 16'h0000; a2_q <= 16'h0000;
        end else begin
            v1_q <= mem_req && mem_gnt; a1_q <= mem_addr;
            v2_q <= v1_q;               a2_q <= a1_q;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] a);
        check_eq({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        check_eq({tag, "_addr"}, {16'd0, inst_addr}, {16'd0, a});
        check_eq({tag, "_inst"}, inst, {16'hA5A5, a});
    endtask

    // Advance to the next cycle's negedge, apply inputs, let them settle.
    task automatic cyc(input logic br, input logic [15:0] ba, input logic st);
        @(negedge clk);
        branch = br; branch_addr = ba; stall = st;
        #1;
    endtask

    // Pulse reset; on return the bench sits in cycle 0 after release.
    task automatic restart(input logic st);
        @(negedge clk);
        rst = 1'b1; branch = 1'b0; stall = st;
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int reqs;
        logic [15:0] a;
        branch = 1'b0; stall = 1'b0; branch_addr = 16'h0000;

        // 1: reset values, then free-run.
        @(negedge clk); #1;
        check_eq("rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_maddr", {16'd0, mem_addr}, 32'd0);
        check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_inst", inst, 32'd0);
        check_eq("rst_iaddr", {16'd0, inst_addr}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        check_eq("t1_req0", {31'd0, mem_req}, 32'd1);
        check_eq("t1_maddr0", {16'd0, mem_addr}, 32'd0);
        check_eq("t1_valid0", {31'd0, inst_valid}, 32'd0);
        cyc(1'b0, 16'h0000, 1'b0);
        check_eq("t1_maddr1", {16'd0, mem_addr}, 32'd1);
        check_eq("t1_valid1", {31'd0, inst_valid}, 32'd0);
        cyc(1'b0, 16'h0000, 1'b0);
        check_eq("t1_valid2", {31'd0, inst_valid}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 16'h0000, 1'b0);
            check_out("t1_stream", 16'(k));
        end

        // 2: stall from the start; credit limit of 4, then drain in order.
        restart(1'b1);
        reqs = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) cyc(1'b0, 16'h0000, 1'b1);
            reqs += int'(mem_req);
            if (c == 3 || c == 9) check_out("t2_hold", 16'h0000);
        end
        check_eq("t2_reqs", 32'(reqs), 32'd4);
        check_eq("t2_req_off", {31'd0, mem_req}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 16'h0000, 1'b0);
            check_out("t2_drain", 16'(k));
        end

        // 3: branch with 2 in flight and 2 queued (one response lands in the branch cycle).
        restart(1'b1);
        for (int c = 1; c < 4; c++) cyc(1'b0, 16'h0000, 1'b1);
        cyc(1'b1, 16'h0100, 1'b0);
        check_eq("t3_br_req", {31'd0, mem_req}, 32'd0);
        check_out("t3_pre", 16'h0000);
        cyc(1'b0, 16'h0000, 1'b0);
        check_eq("t3_valid5", {31'd0, inst_valid}, 32'd0);
        check_eq("t3_maddr5", {16'd0, mem_addr}, 32'h0100);
        check_eq("t3_drop5", 32'(dut.drop_cnt_q), 32'd1);
        cyc(1'b0, 16'h0000, 1'b0);
        check_eq("t3_valid6", {31'd0, inst_valid}, 32'd0);
        cyc(1'b0, 16'h0000, 1'b0);
        check_eq("t3_valid7", {31'd0, inst_valid}, 32'd0);
        cyc(1'b0, 16'h0000, 1'b0);
        check_out("t3_tgt0", 16'h0100);
        cyc(1'b0, 16'h0000, 1'b0);
        check_out("t3_tgt1", 16'h0101);

        // 4: branch coinciding with rvalid and a would-be pop.
        restart(1'b0);
        for (int c = 1; c < 5; c++) cyc(1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 16'h0200, 1'b0);
        check_out("t4_pre", 16'h0002);
        check_eq("t4_rvalid", {31'd0, mem_rvalid}, 32'd1);
        cyc(1'b0, 16'h0000, 1'b0);
        check_eq("t4_valid6", {31'd0, inst_valid}, 32'd0);
        check_eq("t4_drop6", 32'(dut.drop_cnt_q), 32'd1);
        check_eq("t4_count6", 32'(dut.count_q), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0);
        check_eq("t4_valid8", {31'd0, inst_valid}, 32'd0);
        cyc(1'b0, 16'h0000, 1'b0);
        check_out("t4_tgt0", 16'h0200);
        cyc(1'b0, 16'h0000, 1'b0);
        check_out("t4_tgt1", 16'h0201);

        // 5: address wrap after branching near the top.
        restart(1'b0);
        for (int c = 1; c < 5; c++) cyc(1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 16'hFFFE, 1'b0);
        for (int c = 6; c < 9; c++) cyc(1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 16'h0000, 1'b0);
            a = 16'hFFFE + 16'(k);
            check_out("t5_wrap", a);
        end

        // Back-to-back branches: stale count carries across both.
        restart(1'b0);
        for (int c = 1; c < 5; c++) cyc(1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 16'h0300, 1'b0);
        cyc(1'b1, 16'h0400, 1'b0);
        check_eq("bb_req6", {31'd0, mem_req}, 32'd0);
        cyc(1'b0, 16'h0000, 1'b0);
        check_eq("bb_drop7", 32'(dut.drop_cnt_q), 32'd0);
        check_eq("bb_maddr7", {16'd0, mem_addr}, 32'h0400);
        cyc(1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0);
        check_eq("bb_valid9", {31'd0, inst_valid}, 32'd0);
        cyc(1'b0, 16'h0000, 1'b0);
        check_out("bb_tgt", 16'h0400);

        // 6: asynchronous reset mid-stream, then clean restart.
        restart(1'b0);
        for (int c = 1; c < 6; c++) cyc(1'b0, 16'h0000, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_req", {31'd0, mem_req}, 32'd0);
        check_eq("t6_maddr", {16'd0, mem_addr}, 32'd0);
        check_eq("t6_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("t6_inst", inst, 32'd0);
        check_eq("t6_iaddr", {16'd0, inst_addr}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        check_eq("t6_req0", {31'd0, mem_req}, 32'd1);
        cyc(1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0);
        check_eq("t6_valid2", {31'd0, inst_valid}, 32'd0);
        cyc(1'b0, 16'h0000, 1'b0);
        check_out("t6_first", 16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
